// File: rtl/crc_sched_pkg.sv
// crc_sched_pkg: shared widths and scheduler state encoding
package crc_sched_pkg;
    localparam int DATA_W = 96;
    localparam int CRC_W  = 16;
    typedef enum logic [1:0] {ST_IDLE, ST_LAUNCH, ST_WAIT, ST_RESP} state_t;
endpackage

// File: rtl/rr_arbiter_nreq.sv
// rr_arbiter_nreq: combinational round-robin pick of the first requester at or after ptr
module rr_arbiter_nreq
    import crc_sched_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int PTR_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [NREQ-1:0]  o_grant,
    output logic [PTR_W-1:0] o_idx
);
    // scan farthest-to-nearest so the requester closest to ptr overwrites the others
    always_comb begin
        o_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (i_req[(int'(i_ptr) + k) % NREQ]) o_idx = PTR_W'((int'(i_ptr) + k) % NREQ);
        end
        o_grant = (|i_req) ? (NREQ'(1) << o_idx) : '0;
    end
endmodule

// File: rtl/crc16_req_scheduler.sv
// crc16_req_scheduler: shares one CRC16 engine among NREQ requesters, round-robin, with timeout
module crc16_req_scheduler
    import crc_sched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [NREQ-1:0]        i_req_valid,
    input  logic [NREQ*DATA_W-1:0] i_req_data,
    output logic [NREQ-1:0]        o_req_ready,
    output logic [NREQ-1:0]        o_rsp_valid,
    output logic [CRC_W-1:0]       o_rsp_crc,
    output logic                   o_rsp_err,
    output logic                   o_busy,
    output logic                   o_crc_start,
    output logic [DATA_W-1:0]      o_crc_data,
    input  logic                   i_crc_valid,
    input  logic [CRC_W-1:0]       i_crc_result
);
    localparam int PTR_W = $clog2(NREQ);
    localparam int CNT_W = $clog2(TIMEOUT);

    state_t            r_state;
    logic [PTR_W-1:0]  r_ptr;
    logic [PTR_W-1:0]  r_gnt;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_data;
    logic [NREQ-1:0]   r_rsp_valid;
    logic [CRC_W-1:0]  r_rsp_crc;
    logic              r_rsp_err;
    logic              r_busy;
    logic              r_crc_start;
    logic [NREQ-1:0]   w_grant;
    logic [PTR_W-1:0]  w_idx;
    logic [NREQ-1:0]   w_gnt_oh;
    logic              w_xfer;

    rr_arbiter_nreq #(.NREQ(NREQ), .PTR_W(PTR_W)) u_arb (
        .i_req   (i_req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    // ready is only offered in IDLE and is held low while reset is asserted
    assign o_req_ready = (r_state == ST_IDLE && i_rst_n) ? w_grant : '0;
    assign w_xfer      = |(i_req_valid & o_req_ready);
    assign w_gnt_oh    = NREQ'(1) << r_gnt;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_crc   = r_rsp_crc;
    assign o_rsp_err   = r_rsp_err;
    assign o_busy      = r_busy;
    assign o_crc_start = r_crc_start;
    assign o_crc_data  = r_data;

    // job FSM: accept, launch engine, wait for result or timeout, respond
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_gnt       <= '0;
            r_cnt       <= '0;
            r_data      <= '0;
            r_rsp_valid <= '0;
            r_rsp_crc   <= '0;
            r_rsp_err   <= 1'b0;
            r_busy      <= 1'b0;
            r_crc_start <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_xfer) begin
                        r_data      <= i_req_data[int'(w_idx)*DATA_W +: DATA_W];
                        r_gnt       <= w_idx;
                        r_busy      <= 1'b1;
                        r_crc_start <= 1'b1;
                        r_state     <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    r_crc_start <= 1'b0;
                    r_cnt       <= '0;
                    r_state     <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (i_crc_valid) begin
                        r_rsp_valid <= w_gnt_oh;
                        r_rsp_crc   <= i_crc_result;
                        r_rsp_err   <= 1'b0;
                        r_state     <= ST_RESP;
                    end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        r_rsp_valid <= w_gnt_oh;
                        r_rsp_crc   <= '0;
                        r_rsp_err   <= 1'b1;
                        r_state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_rsp_valid <= '0;
                    r_rsp_crc   <= '0;
                    r_rsp_err   <= 1'b0;
                    r_busy      <= 1'b0;
                    r_ptr       <= (r_gnt == PTR_W'(NREQ - 1)) ? '0 : r_gnt + 1'b1;
                    r_state     <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_crc16_req_scheduler.sv
// tb_crc16_req_scheduler: randomized scoreboard bench with an engine model and round-robin reference
module tb_crc16_req_scheduler;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 64;
    localparam int DW      = 96;
    localparam int CW      = 16;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    rsp_valid;
    logic [CW-1:0]      rsp_crc;
    logic               rsp_err;
    logic               busy;
    logic               crc_start;
    logic [DW-1:0]      crc_data;
    logic               crc_valid;
    logic [CW-1:0]      crc_result;

    crc16_req_scheduler #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req_valid  (req_valid),
        .i_req_data   (req_data),
        .o_req_ready  (req_ready),
        .o_rsp_valid  (rsp_valid),
        .o_rsp_crc    (rsp_crc),
        .o_rsp_err    (rsp_err),
        .o_busy       (busy),
        .o_crc_start  (crc_start),
        .o_crc_data   (crc_data),
        .i_crc_valid  (crc_valid),
        .i_crc_result (crc_result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NREQ-1:0] oh;
        logic [CW-1:0]   crc;
        logic            err;
        int              cyc;
    } rsp_t;
    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } start_t;

    rsp_t          rsp_q[$];
    start_t        start_q[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            model_ptr = 0;
    logic [DW-1:0] pay [NREQ];
    int            eng_lat = 4;
    int            rem = 0;
    bit            eng_en = 1'b1;
    bit            spur = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // engine model: done pulse eng_lat cycles after crc_start, result 16'hBEEF, garbage otherwise
    initial begin
        crc_valid = 1'b0;
        crc_result = '0;
        forever begin
            @(negedge clk);
            crc_valid = 1'b0;
            if (rem > 0) begin
                rem--;
                if (rem == 0 && eng_en) crc_valid = 1'b1;
            end
            if (spur) begin
                crc_valid = 1'b1;
                spur = 1'b0;
            end
            if (crc_start && rst_n) rem = eng_lat;
            crc_result = crc_valid ? 16'hBEEF : CW'($urandom);
        end
    end

    // monitor: pops expected launches and responses whenever the DUT presents them
    always @(negedge clk) begin
        if (rst_n) begin
            if (crc_start) begin
                if (start_q.size() == 0) chk("unexpected_crc_start", 1, 0);
                else begin
                    start_t s;
                    s = start_q.pop_front();
                    chk("crc_data", crc_data, s.data);
                    chk("crc_start_cycle", cyc, s.cyc);
                    chk("busy_at_launch", busy, 1);
                end
            end
            if (rsp_valid != '0) begin
                if (rsp_q.size() == 0) chk("unexpected_rsp_valid", rsp_valid, 0);
                else begin
                    rsp_t r;
                    r = rsp_q.pop_front();
                    chk("rsp_valid_onehot", rsp_valid, r.oh);
                    chk("rsp_crc", rsp_crc, r.crc);
                    chk("rsp_err", rsp_err, r.err);
                    chk("rsp_cycle", cyc, r.cyc);
                    chk("busy_at_resp", busy, 1);
                end
            end else chk("rsp_fields_zero_when_idle", {rsp_crc, rsp_err}, 0);
        end
    end

    task automatic rand_pay();
        for (int i = 0; i < NREQ; i++) pay[i] = {$urandom, $urandom, $urandom};
    endtask

    // present requests, wait for the accept, and push what the reference says must follow
    task automatic issue(input logic [NREQ-1:0] mask, input bit drop, input int lat, input bit en);
        int g = -1;
        int t = 0;
        bit ok;
        rsp_t r;
        start_t s;
        for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = pay[i];
        req_valid = mask;
        eng_lat = lat;
        eng_en = en;
        #1;
        while (!(|req_ready) && t < 200) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!(|req_ready)) begin
            chk("accept_timeout", 0, 1);
            return;
        end
        for (int k = 0; k < NREQ; k++)
            if (g < 0 && mask[(model_ptr + k) % NREQ]) g = (model_ptr + k) % NREQ;
        chk("req_ready_grant", req_ready, DW'(1) << g);
        chk("busy_idle_before_accept", busy, 0);
        ok = en && lat <= TIMEOUT;
        s.data = pay[g];
        s.cyc = cyc + 1;
        start_q.push_back(s);
        r.oh = NREQ'(1) << g;
        r.crc = ok ? 16'hBEEF : 16'h0000;
        r.err = !ok;
        r.cyc = ok ? cyc + 2 + lat : cyc + 2 + TIMEOUT;
        rsp_q.push_back(r);
        model_ptr = (g + 1) % NREQ;
        if (drop) begin
            @(posedge clk);
            #1;
            req_valid[g] = 1'b0;
        end
    endtask

    task automatic wait_done();
        int t = 0;
        while (rsp_q.size() != 0 && t < 300) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("response_timeout", rsp_q.size(), 0);
        rsp_q.delete();
        start_q.delete();
    endtask

    task automatic chk_outputs_zero(input string name);
        chk({name, "_ctrl"}, {req_ready, rsp_valid, rsp_crc, rsp_err, busy, crc_start}, 0);
        chk({name, "_crc_data"}, crc_data, 0);
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("reset_outputs");
        rsp_q.delete();
        start_q.delete();
        model_ptr = 0;
        rem = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [NREQ-1:0] m;
        int lat;
        bit en;
        req_valid = '0;
        req_data = '0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk_outputs_zero("initial_reset");
        @(negedge clk);
        rst_n = 1'b1;

        rand_pay();
        pay[1] = 96'hAA5500112233445566778899;
        issue(4'b0010, 1'b1, 4, 1'b1);
        wait_done();

        do_reset();
        req_valid = '0;
        rand_pay();
        repeat (5) begin
            issue(4'b1111, 1'b0, 4, 1'b1);
            wait_done();
        end
        req_valid = '0;

        rand_pay();
        issue(4'b0100, 1'b1, 4, 1'b0);
        wait_done();
        issue(4'b1000, 1'b1, 4, 1'b1);
        wait_done();

        rand_pay();
        issue(4'b0001, 1'b1, TIMEOUT, 1'b1);
        wait_done();
        issue(4'b0010, 1'b1, TIMEOUT - 1, 1'b1);
        wait_done();
        issue(4'b0100, 1'b1, TIMEOUT + 1, 1'b1);
        wait_done();
        issue(4'b1000, 1'b1, 3, 1'b1);
        wait_done();

        rand_pay();
        issue(4'b0010, 1'b1, 4, 1'b0);
        repeat (10) @(negedge clk);
        req_valid = 4'b0101;
        do_reset();
        rand_pay();
        issue(4'b0101, 1'b1, 4, 1'b1);
        wait_done();
        issue(4'b0100, 1'b1, 5, 1'b1);
        wait_done();

        req_valid = '0;
        @(negedge clk);
        spur = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        chk("busy_after_spurious_valid", busy, 0);
        chk("rsp_after_spurious_valid", rsp_valid, 0);
        rand_pay();
        issue(4'b0001, 1'b1, 2, 1'b1);
        wait_done();

        repeat (24) begin
            rand_pay();
            m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            en = $urandom_range(0, 4) != 0;
            lat = en ? $urandom_range(1, TIMEOUT + 6) : $urandom_range(1, 10);
            issue(m, 1'($urandom_range(0, 1)), lat, en);
            wait_done();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
